// File: rtl/cpu_pkg.sv
// Shared pipeline constants and the hazard controller's state type.
package cpu_pkg;

  localparam int unsigned REGW = 4;
  localparam logic [REGW-1:0] R15_ADDR = 4'b1111;

  typedef enum logic {
    IDLE   = 1'b0,
    MCBUSY = 1'b1
  } hz_state_t;

endpackage

// File: rtl/lu_detect.sv
// Combinational load-use detector: the decode instruction needs a register
// that the load currently in EX has not yet produced.
module lu_detect
  import cpu_pkg::*;
(
  input  logic            id_valid,
  input  logic [REGW-1:0] idop1,
  input  logic [REGW-1:0] idop2,
  input  logic            id_r15use,
  input  logic            ex_load,
  input  logic [REGW-1:0] exwrite1,
  output logic            lu
);

  always_comb begin
    lu = id_valid & ex_load &
         ((exwrite1 == idop1) | (exwrite1 == idop2) |
          (id_r15use & (exwrite1 == R15_ADDR)));
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush controller: load-use bubbles, MUL/DIV EX occupancy and
// taken-branch flushes. Define HAZARD_STATS_EN to add stall/flush counters.
module hazard_stall_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned MC_LAT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [REGW-1:0] idop1,
  input  logic [REGW-1:0] idop2,
  input  logic            id_r15use,
  input  logic            ex_load,
  input  logic [REGW-1:0] exwrite1,
  input  logic            ex_mc_start,
  input  logic            branch_taken,
  output logic            pc_stall,
  output logic            ifid_stall,
  output logic            ifid_flush,
  output logic            idex_bubble,
  output logic            ex_hold,
  output logic            mc_busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]     stall_cycles,
  output logic [15:0]     flush_count
`endif
);

  localparam logic [3:0] MC_INIT = 4'(MC_LAT - 1);

  hz_state_t  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       armed_q;
  logic       lu;

  lu_detect u_lu_detect (
    .id_valid  (id_valid),
    .idop1     (idop1),
    .idop2     (idop2),
    .id_r15use (id_r15use),
    .ex_load   (ex_load),
    .exwrite1  (exwrite1),
    .lu        (lu)
  );

  // armed_q holds every output low during reset and the first cycle after it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      armed_q <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    ex_hold     = 1'b0;
    mc_busy     = 1'b0;
    if (armed_q) begin
      unique case (state_q)
        IDLE: begin
          // Branch beats MUL/DIV start (illegal combo) and load-use (squashed).
          if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (ex_mc_start) begin
            ex_hold    = 1'b1;
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            mc_busy    = 1'b1;
            state_d    = MCBUSY;
            cnt_d      = MC_INIT;
          end else if (lu) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
          end
        end
        MCBUSY: begin
          ex_hold    = 1'b1;
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          mc_busy    = 1'b1;
          if (cnt_q <= 4'd1) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_q, flush_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (pc_stall && (stall_q != '1)) stall_q <= stall_q + 16'd1;
      if (ifid_flush && (flush_q != '1)) flush_q <= flush_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: vector table, multi-cycle
// sequences and randomized traffic against a cycle-count reference model.
module tb_hazard_stall_ctrl;
  import cpu_pkg::*;

  localparam int unsigned MC_LAT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_valid, id_r15use, ex_load, ex_mc_start, branch_taken;
  logic [3:0] idop1, idop2, exwrite1;
  logic       pc_stall, ifid_stall, ifid_flush, idex_bubble, ex_hold, mc_busy;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cycles, flush_count;
`endif

  hazard_stall_ctrl #(.MC_LAT(MC_LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .idop1        (idop1),
    .idop2        (idop2),
    .id_r15use    (id_r15use),
    .ex_load      (ex_load),
    .exwrite1     (exwrite1),
    .ex_mc_start  (ex_mc_start),
    .branch_taken (branch_taken),
    .pc_stall     (pc_stall),
    .ifid_stall   (ifid_stall),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .ex_hold      (ex_hold),
    .mc_busy      (mc_busy)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  always #5 clk = ~clk;

  // Output vector order: {pc_stall, ifid_stall, ifid_flush, idex_bubble, ex_hold, mc_busy}
  localparam logic [5:0] O_NONE = 6'b000000;
  localparam logic [5:0] O_LU   = 6'b110100;
  localparam logic [5:0] O_BR   = 6'b001100;
  localparam logic [5:0] O_MC   = 6'b110011;

  int total = 0;
  int bad   = 0;

  // Reference model: busy cycles still owed after the current one.
  int remaining = 0;
  bit armed     = 1'b0;

  typedef struct {
    string      name;
    logic       v;
    logic [3:0] o1, o2;
    logic       r15, ld;
    logic [3:0] w1;
    logic       mc, br;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [5:0] model_exp();
    bit lu;
    lu = id_valid && ex_load &&
         (exwrite1 == idop1 || exwrite1 == idop2 || (id_r15use && exwrite1 == 4'hF));
    if (rst || !armed)    return O_NONE;
    if (remaining > 0)    return O_MC;
    if (branch_taken)     return O_BR;
    if (ex_mc_start)      return O_MC;
    if (lu)               return O_LU;
    return O_NONE;
  endfunction

  task automatic set_in(input logic v, input logic [3:0] o1, input logic [3:0] o2,
                        input logic r15, input logic ld, input logic [3:0] w1,
                        input logic mc, input logic br);
    id_valid = v; idop1 = o1; idop2 = o2; id_r15use = r15;
    ex_load = ld; exwrite1 = w1; ex_mc_start = mc; branch_taken = br;
  endtask

  task automatic check(input logic [5:0] exp, input string nm);
    logic [5:0] act;
    act = {pc_stall, ifid_stall, ifid_flush, idex_bubble, ex_hold, mc_busy};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (pc,ifid_st,flush,bubble,hold,busy)", nm, act, exp);
    end
  endtask

  // Advance the model across the coming rising edge, then move past it.
  task automatic tick();
    if (rst) begin
      remaining = 0;
      armed     = 1'b0;
    end else if (!armed) begin
      armed = 1'b1;
    end else if (remaining > 0) begin
      remaining--;
    end else if (!branch_taken && ex_mc_start) begin
      remaining = MC_LAT - 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic [5:0] exp, input string nm);
    @(negedge clk);
    check(exp, nm);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{"no_hazard",   1, 4'hE, 4'hC, 0, 1, 4'h0, 0, 0, O_NONE};
    vecs[1]  = '{"lu_op2",      1, 4'hE, 4'hC, 0, 1, 4'hC, 0, 0, O_LU};
    vecs[2]  = '{"lu_cleared",  1, 4'hE, 4'hC, 0, 1, 4'h0, 0, 0, O_NONE};
    vecs[3]  = '{"lu_r15",      1, 4'hE, 4'hC, 1, 1, 4'hF, 0, 0, O_LU};
    vecs[4]  = '{"r15_unused",  1, 4'hE, 4'hC, 0, 1, 4'hF, 0, 0, O_NONE};
    vecs[5]  = '{"lu_op1",      1, 4'h3, 4'h5, 0, 1, 4'h3, 0, 0, O_LU};
    vecs[6]  = '{"not_load",    1, 4'h3, 4'h5, 0, 0, 4'h3, 0, 0, O_NONE};
    vecs[7]  = '{"id_invalid",  0, 4'h3, 4'h5, 0, 1, 4'h3, 0, 0, O_NONE};
    vecs[8]  = '{"br_over_lu",  1, 4'h3, 4'h5, 0, 1, 4'h3, 0, 1, O_BR};
    vecs[9]  = '{"br_alone",    0, 4'h0, 4'h0, 0, 0, 4'h1, 0, 1, O_BR};
    vecs[10] = '{"br_over_mc",  0, 4'h0, 4'h0, 0, 0, 4'h1, 1, 1, O_BR};
    vecs[11] = '{"no_mc_entry", 0, 4'h0, 4'h0, 0, 0, 4'h1, 0, 0, O_NONE};

    // Reset and the first cycle after release keep outputs low despite a hazard.
    set_in(1, 4'h3, 4'h5, 0, 1, 4'h3, 0, 0);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cyc(O_NONE, "reset_held");
    rst = 1'b0;
    cyc(O_NONE, "first_after_release");

    for (int i = 0; i < 12; i++) begin
      set_in(vecs[i].v, vecs[i].o1, vecs[i].o2, vecs[i].r15, vecs[i].ld,
             vecs[i].w1, vecs[i].mc, vecs[i].br);
      cyc(vecs[i].exp, vecs[i].name);
    end

    // MUL/DIV: four busy cycles; lu, branch and restart ignored meanwhile.
    set_in(0, 4'h0, 4'h0, 0, 0, 4'h0, 1, 0);
    cyc(O_MC, "mc_t0");
    set_in(1, 4'h3, 4'h5, 0, 1, 4'h3, 0, 0);
    cyc(O_MC, "mc_t1_lu");
    set_in(1, 4'h3, 4'h5, 0, 1, 4'h3, 1, 0);
    cyc(O_MC, "mc_t2_restart");
    set_in(1, 4'h3, 4'h5, 0, 1, 4'h3, 0, 1);
    cyc(O_MC, "mc_t3_branch");
    set_in(0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0);
    cyc(O_NONE, "mc_t4_done");

    // Reset during cycle 2 of 4, then a fresh full-length count.
    set_in(0, 4'h0, 4'h0, 0, 0, 4'h0, 1, 0);
    cyc(O_MC, "rst_mc_t0");
    set_in(0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0);
    cyc(O_MC, "rst_mc_t1");
    #2 rst = 1'b1;
    #1 check(O_NONE, "rst_async");
    tick();
    rst = 1'b0;
    cyc(O_NONE, "rst_release");
    set_in(0, 4'h0, 4'h0, 0, 0, 4'h0, 1, 0);
    cyc(O_MC, "restart_t0");
    set_in(0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0);
    cyc(O_MC, "restart_t1");
    cyc(O_MC, "restart_t2");
    cyc(O_MC, "restart_t3");
    cyc(O_NONE, "restart_t4");

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      logic [3:0] pool [4];
      pool[0] = 4'h0; pool[1] = 4'h1; pool[2] = 4'h2; pool[3] = 4'hF;
      set_in(1'($urandom_range(0, 3) != 0),
             pool[$urandom_range(0, 3)], pool[$urandom_range(0, 3)],
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             pool[$urandom_range(0, 3)],
             1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 6) == 0));
      rst = 1'($urandom_range(0, 49) == 0);
      @(negedge clk);
      check(model_exp(), "random");
      tick();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
